// File: rtl/sample_feeder.sv
// sample_feeder: buffers (input, target) sample pairs written from the pins and
// replays them one per next_i pulse for a programmed number of epochs.
module sample_feeder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned X_W   = 4,
  parameter int unsigned T_W   = 4,
  localparam int unsigned IW   = $clog2(DEPTH),
  localparam int unsigned CW   = IW + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               clear_i,
  input  logic               wr_valid_i,
  input  logic [X_W+T_W-1:0] wr_data_i,
  output logic               wr_ready_o,
  input  logic               start_i,
  input  logic [7:0]         epochs_i,
  input  logic               next_i,
  output logic [X_W-1:0]     x_o,
  output logic [T_W-1:0]     target_o,
  output logic               sample_valid_o,
  output logic [IW-1:0]      sample_idx_o,
  output logic [7:0]         epoch_o,
  output logic [CW-1:0]      count_o,
  output logic               done_o,
  output logic               overflow_o
);

  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q;
  logic [X_W+T_W-1:0]   mem_q [DEPTH];
  logic [CW-1:0]        count_q;
  logic [IW-1:0]        idx_q;
  logic [7:0]           epoch_q;
  logic [7:0]           epochs_q;
  logic                 overflow_q;
  logic [X_W-1:0]       x_q;
  logic [T_W-1:0]       target_q;

  logic                 start_ok;
  logic                 wr_ok;
  logic                 last_idx;
  logic                 last_epoch;
  logic [IW-1:0]        idx_inc;
  logic [X_W+T_W-1:0]   rd_first;
  logic [X_W+T_W-1:0]   rd_next;

  // Acceptance decodes and read ports for the next sample.
  always_comb begin
    // Start is judged on the pre-write count; an accepted start swallows a same-cycle write.
    start_ok   = en_i & start_i & ~clear_i & (state_q != StRun) &
                 (count_q != '0) & (epochs_i != 8'd0);
    wr_ready_o = en_i & (state_q == StIdle) & (count_q < DepthC);
    wr_ok      = wr_ready_o & wr_valid_i & ~clear_i & ~start_ok;
    last_idx   = ({1'b0, idx_q} == (count_q - CW'(1)));
    // Terminal compare happens before any increment, so epoch_q never wraps.
    last_epoch = (epoch_q == (epochs_q - 8'd1));
    idx_inc    = idx_q + IW'(1);
    rd_first   = mem_q[0];
    rd_next    = mem_q[idx_inc];
  end

  // Sample storage; not cleared by reset or clear_i.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_ok) begin
      mem_q[count_q[IW-1:0]] <= wr_data_i;
    end
  end

  // Control FSM with registered sample outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      count_q    <= '0;
      idx_q      <= '0;
      epoch_q    <= 8'd0;
      epochs_q   <= 8'd0;
      overflow_q <= 1'b0;
      x_q        <= '0;
      target_q   <= '0;
    end else if (en_i) begin
      if (clear_i) begin
        state_q    <= StIdle;
        count_q    <= '0;
        idx_q      <= '0;
        epoch_q    <= 8'd0;
        overflow_q <= 1'b0;
        x_q        <= '0;
        target_q   <= '0;
      end else if (start_ok) begin
        state_q  <= StRun;
        epochs_q <= epochs_i;
        idx_q    <= '0;
        epoch_q  <= 8'd0;
        x_q      <= rd_first[X_W-1:0];
        target_q <= rd_first[X_W +: T_W];
      end else begin
        case (state_q)
          StIdle: begin
            if (wr_valid_i) begin
              if (wr_ok) begin
                count_q <= count_q + CW'(1);
              end else begin
                overflow_q <= 1'b1;
              end
            end
          end
          StRun: begin
            if (next_i) begin
              if (!last_idx) begin
                idx_q    <= idx_inc;
                x_q      <= rd_next[X_W-1:0];
                target_q <= rd_next[X_W +: T_W];
              end else if (!last_epoch) begin
                idx_q    <= '0;
                epoch_q  <= epoch_q + 8'd1;
                x_q      <= rd_first[X_W-1:0];
                target_q <= rd_first[X_W +: T_W];
              end else begin
                state_q  <= StDone;
                idx_q    <= '0;
                x_q      <= '0;
                target_q <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign x_o            = x_q;
  assign target_o       = target_q;
  assign sample_valid_o = (state_q == StRun);
  assign done_o         = (state_q == StDone);
  assign sample_idx_o   = idx_q;
  assign epoch_o        = epoch_q;
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_sample_feeder.sv
// Directed bench for sample_feeder with hand-computed expectations.
module tb_sample_feeder;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic       clear_i;
  logic       wr_valid_i;
  logic [7:0] wr_data_i;
  logic       wr_ready_o;
  logic       start_i;
  logic [7:0] epochs_i;
  logic       next_i;
  logic [3:0] x_o;
  logic [3:0] target_o;
  logic       sample_valid_o;
  logic [2:0] sample_idx_o;
  logic [7:0] epoch_o;
  logic [3:0] count_o;
  logic       done_o;
  logic       overflow_o;

  int checks = 0;
  int errors = 0;

  sample_feeder #(.DEPTH(8), .X_W(4), .T_W(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .en_i           (en_i),
    .clear_i        (clear_i),
    .wr_valid_i     (wr_valid_i),
    .wr_data_i      (wr_data_i),
    .wr_ready_o     (wr_ready_o),
    .start_i        (start_i),
    .epochs_i       (epochs_i),
    .next_i         (next_i),
    .x_o            (x_o),
    .target_o       (target_o),
    .sample_valid_o (sample_valid_o),
    .sample_idx_o   (sample_idx_o),
    .epoch_o        (epoch_o),
    .count_o        (count_o),
    .done_o         (done_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_sample(input logic [7:0] data);
    wr_valid_i = 1'b1;
    wr_data_i  = data;
    tick();
    wr_valid_i = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_x   [6];
    logic [2:0] exp_idx [6];
    logic [7:0] exp_ep  [6];
    exp_x   = '{4'd3, 4'd5, 4'd1, 4'd3, 4'd5, 4'd0};
    exp_idx = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
    exp_ep  = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1};

    rst_i = 1'b1; en_i = 1'b1; clear_i = 1'b0; wr_valid_i = 1'b0; wr_data_i = 8'h00;
    start_i = 1'b0; epochs_i = 8'd0; next_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;

    // Reset state
    check("rst_valid", sample_valid_o, 0);
    check("rst_done", done_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_count", count_o, 0);
    check("rst_epoch", epoch_o, 0);
    check("rst_idx", sample_idx_o, 0);
    check("rst_x", x_o, 0);
    check("rst_target", target_o, 0);
    check("rdy_en_hi", wr_ready_o, 1);
    en_i = 1'b0;
    #1;
    check("rdy_en_lo", wr_ready_o, 0);
    en_i = 1'b1;

    // next_i in IDLE is ignored
    next_i = 1'b1;
    tick();
    next_i = 1'b0;
    check("idle_next_count", count_o, 0);
    check("idle_next_idx", sample_idx_o, 0);

    // Start with empty buffer is ignored
    start_i = 1'b1; epochs_i = 8'd2;
    tick();
    start_i = 1'b0;
    check("empty_start_valid", sample_valid_o, 0);
    check("empty_start_done", done_o, 0);

    // Load three samples
    write_sample(8'h21);
    check("load1_count", count_o, 1);
    write_sample(8'h43);
    write_sample(8'h65);
    check("load3_count", count_o, 3);

    // Start with epochs 0 is ignored
    start_i = 1'b1; epochs_i = 8'd0;
    tick();
    start_i = 1'b0;
    check("ep0_valid", sample_valid_o, 0);
    check("ep0_done", done_o, 0);

    // Accepted start, two epochs
    start_i = 1'b1; epochs_i = 8'd2;
    tick();
    start_i = 1'b0;
    check("start_valid", sample_valid_o, 1);
    check("start_x", x_o, 1);
    check("start_target", target_o, 2);
    check("start_epoch", epoch_o, 0);
    check("start_idx", sample_idx_o, 0);

    // Writes in RUN are ignored
    wr_valid_i = 1'b1; wr_data_i = 8'h99;
    #1;
    check("run_wr_ready", wr_ready_o, 0);
    tick();
    wr_valid_i = 1'b0;
    check("run_wr_count", count_o, 3);
    check("run_wr_idx", sample_idx_o, 0);
    check("run_wr_ovf", overflow_o, 0);

    // Six back-to-back next pulses
    next_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("seq_x_%0d", i), x_o, exp_x[i]);
      check($sformatf("seq_idx_%0d", i), sample_idx_o, exp_idx[i]);
      check($sformatf("seq_ep_%0d", i), epoch_o, exp_ep[i]);
    end
    next_i = 1'b0;
    check("seq_done", done_o, 1);
    check("seq_valid_low", sample_valid_o, 0);
    tick();
    check("done_holds", done_o, 1);

    // Restart from DONE
    start_i = 1'b1; epochs_i = 8'd2;
    tick();
    start_i = 1'b0;
    check("restart_valid", sample_valid_o, 1);
    check("restart_done", done_o, 0);
    check("restart_x", x_o, 1);
    check("restart_epoch", epoch_o, 0);

    next_i = 1'b1;
    tick();
    next_i = 1'b0;
    check("pre_freeze_x", x_o, 3);

    // Freeze: pulses while en_i low are lost
    en_i = 1'b0; next_i = 1'b1; start_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("freeze_x_%0d", i), x_o, 3);
      check($sformatf("freeze_idx_%0d", i), sample_idx_o, 1);
      check($sformatf("freeze_valid_%0d", i), sample_valid_o, 1);
    end
    en_i = 1'b1; next_i = 1'b0; start_i = 1'b0;
    tick();
    check("resume_x", x_o, 3);
    check("resume_idx", sample_idx_o, 1);
    next_i = 1'b1;
    tick();
    next_i = 1'b0;
    check("resume_adv_x", x_o, 5);

    // Advance to idx 2, epoch 1 then reset
    next_i = 1'b1;
    tick();
    tick();
    tick();
    next_i = 1'b0;
    check("mid_idx", sample_idx_o, 2);
    check("mid_epoch", epoch_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midrst_valid", sample_valid_o, 0);
    check("midrst_count", count_o, 0);
    check("midrst_epoch", epoch_o, 0);
    check("midrst_ready", wr_ready_o, 1);

    // Overflow on the ninth write
    for (int i = 0; i < 9; i++) begin
      wr_valid_i = 1'b1;
      wr_data_i  = 8'(i);
      #1;
      if (i == 8) check("full_ready", wr_ready_o, 0);
      tick();
    end
    wr_valid_i = 1'b0;
    check("full_count", count_o, 8);
    check("full_ovf", overflow_o, 1);
    tick();
    tick();
    check("ovf_sticky", overflow_o, 1);

    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clr_ovf", overflow_o, 0);
    check("clr_count", count_o, 0);

    // Start and write in the same IDLE cycle: start wins
    write_sample(8'h87);
    start_i = 1'b1; epochs_i = 8'd1; wr_valid_i = 1'b1; wr_data_i = 8'hAA;
    tick();
    start_i = 1'b0; wr_valid_i = 1'b0;
    check("sw_count", count_o, 1);
    check("sw_valid", sample_valid_o, 1);
    check("sw_x", x_o, 7);
    check("sw_target", target_o, 8);
    next_i = 1'b1;
    tick();
    next_i = 1'b0;
    check("one_ep_done", done_o, 1);

    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clr_done", done_o, 0);
    check("clr_epoch", epoch_o, 0);
    check("clr_ready", wr_ready_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
